// File: rtl/bcd_scan_counter_if.sv
// Control and display bus of the BCD scan counter.
// The master drives the count requests. The slave (the counter) returns the
// count value and the scanned digit.
interface bcd_scan_counter_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    en;
   logic                    up_dn;
   logic                    clr;
   logic [4*NUM_DIGITS-1:0] count_bcd;
   logic                    carry_out;
   logic [3:0]              bcd_out;
   logic [NUM_DIGITS-1:0]   digit_sel;

   modport master (
      output en, up_dn, clr,
      input  count_bcd, carry_out, bcd_out, digit_sel
   );

   modport slave (
      input  en, up_dn, clr,
      output count_bcd, carry_out, bcd_out, digit_sel
   );
endinterface

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down event counter with a time-multiplexed digit scanner.
// Every output is registered, so the downstream 7-segment decoder sees
// glitch-free values.
module bcd_scan_counter #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000
) (
   input  logic                clk,
   input  logic                rst_n,
   bcd_scan_counter_if.slave   bus
);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(SCAN_DIV - 1);

   logic [NUM_DIGITS-1:0][3:0] cnt, cnt_nxt;
   logic                       wrap;
   logic                       carry_q;
   logic [DIV_W-1:0]           div;
   logic [IDX_W-1:0]           idx, idx_nxt;
   logic                       scan_edge;
   logic [3:0]                 bcd_q;
   logic [NUM_DIGITS-1:0]      sel_q;

   // Ripple one step through the digits. The carry (or borrow) survives
   // past the top digit only when every digit was at its limit. That case
   // is a wrap.
   always_comb begin
      logic c;
      cnt_nxt = cnt;
      c       = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (c) begin
            if (bus.up_dn) begin
               if (cnt[i] == 4'd9) cnt_nxt[i] = 4'd0;
               else begin
                  cnt_nxt[i] = cnt[i] + 4'd1;
                  c          = 1'b0;
               end
            end else begin
               if (cnt[i] == 4'd0) cnt_nxt[i] = 4'd9;
               else begin
                  cnt_nxt[i] = cnt[i] - 4'd1;
                  c          = 1'b0;
               end
            end
         end
      end
      wrap = c;
   end

   // Count register: clr has priority over en. carry_out is high only on a wrap step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         carry_q <= 1'b0;
      end else if (bus.clr) begin
         cnt     <= '0;
         carry_q <= 1'b0;
      end else if (bus.en) begin
         cnt     <= cnt_nxt;
         carry_q <= wrap;
      end else begin
         carry_q <= 1'b0;
      end
   end

   assign scan_edge = (div == LAST_DIV);
   assign idx_nxt   = !scan_edge        ? idx :
                      (idx == LAST_IDX) ? '0  : idx + 1'b1;

   // Free-running slot divider and scan index. They do not depend on en or clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div <= '0;
         idx <= '0;
      end else begin
         div <= scan_edge ? '0 : div + 1'b1;
         idx <= idx_nxt;
      end
   end

   // Display outputs. bcd_out is reloaded on every edge from the current
   // count, so a count change shows up one cycle later, even in the middle
   // of a slot. With a single digit the shift is always by 0, so digit_sel
   // stays at 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_q <= 4'h0;
         sel_q <= NUM_DIGITS'(1);
      end else begin
         bcd_q <= cnt[idx_nxt];
         sel_q <= NUM_DIGITS'(1) << idx_nxt;
      end
   end

   assign bus.count_bcd = cnt;
   assign bus.carry_out = carry_q;
   assign bus.bcd_out   = bcd_q;
   assign bus.digit_sel = sel_q;
endmodule

// File: tb/tb_bcd_scan_counter.sv
// Randomized and directed checks of bcd_scan_counter against a decimal reference model.
module tb_bcd_scan_counter;
   localparam int N    = 4;
   localparam int SD   = 4;
   localparam int MAXV = 10000;

   logic clk = 1'b0;
   logic rst_n;
   int   n_vec = 0;
   int   n_err = 0;

   // Reference state: the count as a plain integer, the expected carry, and the edges since reset.
   int unsigned mval;
   bit          mcy;
   int          k;

   bcd_scan_counter_if #(.NUM_DIGITS(N)) bus ();

   bcd_scan_counter #(.NUM_DIGITS(N), .SCAN_DIV(SD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int dig(input int unsigned v, input int i);
      int unsigned p = 1;
      for (int j = 0; j < i; j++) p = p * 10;
      return int'((v / p) % 10);
   endfunction

   function automatic logic [31:0] to_bcd(input int unsigned v);
      logic [31:0] r = '0;
      for (int i = 0; i < N; i++) r[4*i +: 4] = 4'(dig(v, i));
      return r;
   endfunction

   // Apply one cycle of inputs, advance the model and compare all outputs.
   task automatic tick(input bit e, input bit u, input bit c);
      int eidx, ebcd;
      bus.en = e; bus.up_dn = u; bus.clr = c;
      @(posedge clk);
      k++;
      eidx = (k / SD) % N;
      ebcd = dig(mval, eidx);
      if (c) begin
         mval = 0; mcy = 1'b0;
      end else if (e && u) begin
         mcy  = (mval == MAXV - 1);
         mval = (mval + 1) % MAXV;
      end else if (e) begin
         mcy  = (mval == 0);
         mval = (mval + MAXV - 1) % MAXV;
      end else begin
         mcy = 1'b0;
      end
      #1;
      chk("count", 32'(bus.count_bcd), to_bcd(mval));
      chk("carry", 32'(bus.carry_out), 32'(mcy));
      chk("bcd_out", 32'(bus.bcd_out), 32'(ebcd));
      chk("digit_sel", 32'(bus.digit_sel), 32'(1) << eidx);
   endtask

   task automatic release_reset;
      @(negedge clk);
      rst_n = 1'b1;
      k = 0; mval = 0; mcy = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      bus.en = 1'b0; bus.up_dn = 1'b0; bus.clr = 1'b0;
      #12;
      chk("rst_count", 32'(bus.count_bcd), 32'h0);
      chk("rst_sel", 32'(bus.digit_sel), 32'h1);
      chk("rst_bcd", 32'(bus.bcd_out), 32'h0);
      chk("rst_carry", 32'(bus.carry_out), 32'h0);
      release_reset();

      // Asynchronous reset in the middle of counting, at 0375.
      for (int i = 0; i < 375; i++) tick(1'b1, 1'b1, 1'b0);
      chk("t1_pre", 32'(bus.count_bcd), 32'h0375);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t1_count", 32'(bus.count_bcd), 32'h0);
      chk("t1_sel", 32'(bus.digit_sel), 32'h1);
      chk("t1_bcd", 32'(bus.bcd_out), 32'h0);
      chk("t1_carry", 32'(bus.carry_out), 32'h0);
      release_reset();

      // Ripple from 0009 to 0010.
      for (int i = 0; i < 9; i++) tick(1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      chk("t2_count", 32'(bus.count_bcd), 32'h0010);
      chk("t2_carry", 32'(bus.carry_out), 32'h0);

      // Wraps in both directions.
      for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      chk("t3_dn_count", 32'(bus.count_bcd), 32'h9999);
      chk("t3_dn_carry", 32'(bus.carry_out), 32'h1);
      tick(1'b0, 1'b0, 1'b0);
      chk("t3_dn_pulse", 32'(bus.carry_out), 32'h0);
      tick(1'b1, 1'b1, 1'b0);
      chk("t3_up_count", 32'(bus.count_bcd), 32'h0000);
      chk("t3_up_carry", 32'(bus.carry_out), 32'h1);
      tick(1'b0, 1'b1, 1'b0);
      chk("t3_up_pulse", 32'(bus.carry_out), 32'h0);

      // clr beats a simultaneous wrap.
      tick(1'b1, 1'b0, 1'b0);
      chk("t5_pre", 32'(bus.count_bcd), 32'h9999);
      tick(1'b1, 1'b1, 1'b1);
      chk("t5_count", 32'(bus.count_bcd), 32'h0);
      chk("t5_carry", 32'(bus.carry_out), 32'h0);

      // Hold at 4321 and watch the scan walk through the digits.
      for (int i = 0; i < 4321; i++) tick(1'b1, 1'b1, 1'b0);
      chk("t4_pre", 32'(bus.count_bcd), 32'h4321);
      for (int i = 0; i < 24; i++) begin
         tick(1'b0, 1'b1, 1'b0);
         chk("t4_onehot", 32'($onehot(bus.digit_sel)), 32'h1);
      end

      // Random traffic with occasional clears.
      for (int i = 0; i < 10000; i++) begin
         bit e, u, c;
         e = 1'($urandom_range(0, 3) != 0);
         u = 1'($urandom_range(0, 1));
         c = 1'($urandom_range(0, 199) == 0);
         tick(e, u, c);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
